// File: rtl/foxtrot_pkg.sv
// foxtrot_pkg: shared dispatch entry type and FU class constants
package foxtrot_pkg;
  localparam int ID_W = 6;
  localparam int PRN_W = 6;
  localparam int OPS = 3;
  localparam int FUS = 4;
  localparam int CLS_W = 2;
  localparam logic [CLS_W-1:0] FU_LSU = 2'd0;
  localparam logic [CLS_W-1:0] FU_BRANCH = 2'd1;
  localparam logic [CLS_W-1:0] FU_ARITH = 2'd2;
  localparam logic [CLS_W-1:0] FU_MISC = 2'd3;
  typedef struct packed {
    logic [ID_W-1:0] inst_id;
    logic [31:0] raw_instr;
    logic [63:0] instr_pc;
    logic [OPS-1:0] prn_input_valid;
    logic [OPS-1:0] prn_input_ready;
    logic [OPS-1:0][PRN_W-1:0] prn_input;
    logic [OPS-1:0] prn_output_valid;
    logic [OPS-1:0][PRN_W-1:0] prn_output;
    logic [CLS_W-1:0] fu_class;
  } dispatch_entry_t;
endpackage

// File: rtl/fu_class_decode.sv
// fu_class_decode: maps an instruction encoding to its functional-unit class
module fu_class_decode
  import foxtrot_pkg::*;
(
  input  logic [31:0]      raw_instr,
  output logic [CLS_W-1:0] fu_class
);
  logic [3:0] b;
  logic unused_bits;
  assign b = raw_instr[28:25];
  assign unused_bits = ^{raw_instr[31:29], raw_instr[24:0]};
  assign fu_class = (b[2] && !b[0]) ? FU_LSU :
                    (b[3:1] == 3'b101) ? FU_BRANCH :
                    (b[3:1] == 3'b100 || b[2:0] == 3'b101) ? FU_ARITH : FU_MISC;
endmodule

// File: rtl/dispatch_router.sv
// dispatch_router: in-order dispatch FIFO with FU classification and operand wakeup
module dispatch_router
  import foxtrot_pkg::*;
#(
  parameter int INST_ID_BITS = ID_W,
  parameter int PRN_BITS = PRN_W,
  parameter int MAX_OPERANDS = OPS,
  parameter int FU_COUNT = FUS,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INST_ID_BITS-1:0] in_inst_id,
  input  logic [31:0]             in_raw_instr,
  input  logic [63:0]             in_instr_pc,
  input  logic                    in_prn_input_valid [MAX_OPERANDS],
  input  logic                    in_prn_input_ready [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     in_prn_input [MAX_OPERANDS],
  input  logic                    in_prn_output_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     in_prn_output [MAX_OPERANDS],
  input  logic                    set_prn_ready [FU_COUNT][MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     set_prn [FU_COUNT][MAX_OPERANDS],
  input  logic                    queue_ready [FU_COUNT],
  output logic                    inst_valid [FU_COUNT],
  output logic [INST_ID_BITS-1:0] inst_id,
  output logic [31:0]             raw_instr,
  output logic [63:0]             instr_pc,
  output logic                    prn_input_valid [MAX_OPERANDS],
  output logic                    prn_input_ready [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prn_input [MAX_OPERANDS],
  output logic                    prn_output_valid [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prn_output [MAX_OPERANDS]
);
  localparam int PW = $clog2(DEPTH);
  dispatch_entry_t mem [DEPTH];
  dispatch_entry_t in_entry, hd;
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic [CLS_W-1:0] in_class;
  logic head_valid, push, pop;
  function automatic logic hit(input logic [PRN_BITS-1:0] p);
    hit = 1'b0;
    for (int f = 0; f < FU_COUNT; f++)
      for (int j = 0; j < MAX_OPERANDS; j++)
        hit |= set_prn_ready[f][j] && set_prn[f][j] == p;
  endfunction
  fu_class_decode u_dec (.raw_instr(in_raw_instr), .fu_class(in_class));
  // incoming entry, with operands already woken by this cycle's broadcasts
  always_comb begin
    in_entry = '0;
    in_entry.inst_id = in_inst_id;
    in_entry.raw_instr = in_raw_instr;
    in_entry.instr_pc = in_instr_pc;
    in_entry.fu_class = in_class;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      in_entry.prn_input_valid[i] = in_prn_input_valid[i];
      in_entry.prn_input_ready[i] = in_prn_input_ready[i] | (in_prn_input_valid[i] & hit(in_prn_input[i]));
      in_entry.prn_input[i] = in_prn_input[i];
      in_entry.prn_output_valid[i] = in_prn_output_valid[i];
      in_entry.prn_output[i] = in_prn_output[i];
    end
  end
  // head presentation and handshake; ready bits include same-cycle wakeups
  always_comb begin
    hd = mem[head];
    head_valid = |count;
    in_ready = !count[PW];
    push = in_valid && in_ready && !flush;
    pop = head_valid && queue_ready[hd.fu_class] && !flush;
    for (int k = 0; k < FU_COUNT; k++)
      inst_valid[k] = head_valid && hd.fu_class == CLS_W'(k) && queue_ready[k] && !flush;
    inst_id = hd.inst_id;
    raw_instr = hd.raw_instr;
    instr_pc = hd.instr_pc;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      prn_input_valid[i] = hd.prn_input_valid[i];
      prn_input_ready[i] = hd.prn_input_ready[i] | (hd.prn_input_valid[i] & hit(hd.prn_input[i]));
      prn_input[i] = hd.prn_input[i];
      prn_output_valid[i] = hd.prn_output_valid[i];
      prn_output[i] = hd.prn_output[i];
    end
  end
  // FIFO pointers, occupancy, storage and sticky operand wakeup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++)
        for (int i = 0; i < MAX_OPERANDS; i++)
          if (mem[e].prn_input_valid[i] && hit(mem[e].prn_input[i])) mem[e].prn_input_ready[i] <= 1'b1;
      if (push) mem[tail] <= in_entry;
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
endmodule

// File: tb/tb_dispatch_router.sv
// tb_dispatch_router: scoreboard bench for the in-order dispatch buffer
module tb_dispatch_router;
  localparam logic [31:0] ADD = 32'h91000420, LDR = 32'hF9400020, BR = 32'h14000010;
  typedef struct packed {
    logic [3:0] vec;
    logic [5:0] id;
    logic [2:0] rdy;
    logic [63:0] pc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic in_ready;
  logic [5:0] in_inst_id = '0;
  logic [31:0] in_raw_instr = '0;
  logic [63:0] in_instr_pc = '0;
  logic in_prn_input_valid [3], in_prn_input_ready [3], in_prn_output_valid [3];
  logic [5:0] in_prn_input [3], in_prn_output [3];
  logic set_prn_ready [4][3];
  logic [5:0] set_prn [4][3];
  logic queue_ready [4], inst_valid [4];
  logic [5:0] inst_id;
  logic [31:0] raw_instr;
  logic [63:0] instr_pc;
  logic prn_input_valid [3], prn_input_ready [3], prn_output_valid [3];
  logic [5:0] prn_input [3], prn_output [3];
  logic [3:0] iv_p;
  logic [2:0] rdy_p;
  exp_t sb [$];
  int checks = 0, fails = 0;
  dispatch_router dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_instr_pc(in_instr_pc),
    .in_prn_input_valid(in_prn_input_valid), .in_prn_input_ready(in_prn_input_ready),
    .in_prn_input(in_prn_input), .in_prn_output_valid(in_prn_output_valid),
    .in_prn_output(in_prn_output), .set_prn_ready(set_prn_ready), .set_prn(set_prn),
    .queue_ready(queue_ready), .inst_valid(inst_valid), .inst_id(inst_id),
    .raw_instr(raw_instr), .instr_pc(instr_pc), .prn_input_valid(prn_input_valid),
    .prn_input_ready(prn_input_ready), .prn_input(prn_input),
    .prn_output_valid(prn_output_valid), .prn_output(prn_output)
  );
  always #5 clk = ~clk;
  always_comb begin
    for (int k = 0; k < 4; k++) iv_p[k] = inst_valid[k];
    for (int i = 0; i < 3; i++) rdy_p[i] = prn_input_ready[i];
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic set_qr(input logic [3:0] v);
    for (int k = 0; k < 4; k++) queue_ready[k] = v[k];
  endtask
  task automatic drive(input logic [5:0] id, input logic [31:0] ins, input logic [2:0] pv, input logic [5:0] p0);
    in_inst_id = id;
    in_raw_instr = ins;
    in_instr_pc = 64'h1000 + 64'(id) * 4;
    for (int i = 0; i < 3; i++) begin
      in_prn_input_valid[i] = pv[i];
      in_prn_input_ready[i] = 1'b0;
      in_prn_input[i] = (i == 0) ? p0 : 6'd0;
    end
  endtask
  task automatic push(input logic [5:0] id, input logic [31:0] ins, input logic [3:0] vec, input logic [2:0] pv, input logic [5:0] p0, input logic [2:0] rdy, input bit exp);
    drive(id, ins, pv, p0);
    in_valid = 1'b1;
    if (exp) sb.push_back('{vec: vec, id: id, rdy: rdy, pc: 64'h1000 + 64'(id) * 4});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // monitor: every dispatch strobe must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && iv_p != 4'b0) begin
      if (sb.size() == 0) chk("unexpected_dispatch", {58'd0, inst_id}, 64'hFFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("dispatch_vec", 64'(iv_p), 64'(e.vec));
        chk("dispatch_id", 64'(inst_id), 64'(e.id));
        chk("dispatch_pc", instr_pc, e.pc);
        chk("dispatch_rdy", 64'(rdy_p), 64'(e.rdy));
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      in_prn_input_valid[i] = 1'b0;
      in_prn_input_ready[i] = 1'b0;
      in_prn_input[i] = '0;
      in_prn_output_valid[i] = 1'b0;
      in_prn_output[i] = '0;
      for (int f = 0; f < 4; f++) begin
        set_prn_ready[f][i] = 1'b0;
        set_prn[f][i] = '0;
      end
    end
    set_qr(4'b1111);
    cyc(2);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_inst_valid", 64'(iv_p), 64'd0);
    chk("reset_inst_id", 64'(inst_id), 64'd0);
    chk("reset_pc", instr_pc, 64'd0);
    rst = 1'b0;
    cyc(1);
    push(6'd1, ADD, 4'b0100, 3'b000, 6'd0, 3'b000, 1'b1);
    chk("add_in_ready", 64'(in_ready), 64'd1);
    cyc(2);
    set_qr(4'b1110);
    for (int n = 0; n < 4; n++) push(6'(2 + n), LDR, 4'b0001, 3'b000, 6'd0, 3'b000, 1'b1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("blocked_lsu", 64'(iv_p), 64'd0);
    set_qr(4'b1111);
    cyc(4);
    chk("ldr_drained", 64'(sb.size()), 64'd0);
    chk("drained_in_ready", 64'(in_ready), 64'd1);
    set_qr(4'b1101);
    push(6'd6, BR, 4'b0010, 3'b000, 6'd0, 3'b000, 1'b1);
    push(6'd7, ADD, 4'b0100, 3'b000, 6'd0, 3'b000, 1'b1);
    cyc(3);
    chk("hol_blocked", 64'(iv_p), 64'd0);
    set_qr(4'b1111);
    cyc(3);
    chk("hol_drained", 64'(sb.size()), 64'd0);
    set_qr(4'b1011);
    push(6'd8, ADD, 4'b0100, 3'b001, 6'd9, 3'b001, 1'b1);
    push(6'd9, ADD, 4'b0100, 3'b001, 6'd10, 3'b001, 1'b1);
    chk("wake_before", 64'(rdy_p), 64'd0);
    set_prn_ready[3][1] = 1'b1;
    set_prn[3][1] = 6'd9;
    #1 chk("wake_same_cycle", 64'(rdy_p), 64'd1);
    cyc(1);
    set_prn_ready[3][1] = 1'b0;
    set_prn[3][1] = 6'd0;
    #1 chk("wake_stored", 64'(rdy_p), 64'd1);
    set_qr(4'b1111);
    cyc(1);
    chk("head9_not_ready", 64'(rdy_p), 64'd0);
    set_prn_ready[0][2] = 1'b1;
    set_prn[0][2] = 6'd10;
    cyc(1);
    set_prn_ready[0][2] = 1'b0;
    set_prn[0][2] = 6'd0;
    chk("wake_drained", 64'(sb.size()), 64'd0);
    set_qr(4'b1110);
    for (int n = 0; n < 4; n++) push(6'(10 + n), LDR, 4'b0001, 3'b000, 6'd0, 3'b000, 1'b1);
    chk("full2_in_ready", 64'(in_ready), 64'd0);
    drive(6'd14, LDR, 3'b000, 6'd0);
    in_valid = 1'b1;
    set_qr(4'b1111);
    cyc(1);
    in_valid = 1'b0;
    set_qr(4'b1110);
    #1 chk("full_pop_frees", 64'(in_ready), 64'd1);
    drive(6'd15, LDR, 3'b000, 6'd0);
    in_valid = 1'b1;
    sb.push_back('{vec: 4'b0001, id: 6'd15, rdy: 3'b000, pc: 64'h1000 + 64'd15 * 4});
    set_qr(4'b1111);
    cyc(1);
    in_valid = 1'b0;
    set_qr(4'b1110);
    #1 chk("pushpop_count3", 64'(in_ready), 64'd1);
    push(6'd16, LDR, 4'b0001, 3'b000, 6'd0, 3'b000, 1'b1);
    chk("pushpop_then_full", 64'(in_ready), 64'd0);
    set_qr(4'b1111);
    cyc(5);
    chk("full2_drained", 64'(sb.size()), 64'd0);
    set_qr(4'b1011);
    for (int n = 0; n < 3; n++) push(6'(20 + n), ADD, 4'b0100, 3'b000, 6'd0, 3'b000, 1'b0);
    drive(6'd23, ADD, 3'b000, 6'd0);
    in_valid = 1'b1;
    flush = 1'b1;
    set_qr(4'b1111);
    #1 chk("flush_no_dispatch", 64'(iv_p), 64'd0);
    cyc(1);
    flush = 1'b0;
    in_valid = 1'b0;
    #1 chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_empty", 64'(iv_p), 64'd0);
    cyc(2);
    chk("flush_not_stored", 64'(iv_p), 64'd0);
    set_qr(4'b1011);
    push(6'd30, ADD, 4'b0100, 3'b000, 6'd0, 3'b000, 1'b0);
    #2 rst = 1'b1;
    set_qr(4'b1111);
    #1 chk("async_rst_no_dispatch", 64'(iv_p), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
